// File: rtl/alarm_clock_multi.sv
// Alarm clock core: 24 h time counter, NUM_ALARMS alarm slots, ring/snooze FSM
// and display mux, all on one clock with tick_sec/tick_adj enables.
module alarm_clock_multi #(
    parameter  int NUM_ALARMS = 4,
    parameter  int RING_SECS  = 10,
    parameter  int SNOOZE_MIN = 5,
    localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  tick_sec,
    input  logic                  tick_adj,
    input  logic [1:0]            mode,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [5:0]            adjustline,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [7:0]            hour,
    output logic [7:0]            minute,
    output logic [7:0]            second,
    output logic [7:0]            dis_hour,
    output logic [7:0]            dis_min,
    output logic [7:0]            dis_sec,
    output logic                  ringing,
    output logic [AW-1:0]         ring_id,
    output logic                  adjusting,
    output logic                  setting
);
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

    function automatic logic [7:0] edit_hour(input logic [7:0] h, input logic tens,
                                             input logic units);
        logic [7:0] r;
        r = h;
        if (tens) begin
            if (h < 8'd14)      r = h + 8'd10;
            else if (h < 8'd20) r = h - 8'd10;
            else                r = h - 8'd20;
        end else if (units) begin
            r = (h == 8'd23) ? 8'd0 : h + 8'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] edit_ms(input logic [7:0] v, input logic tens,
                                           input logic units);
        logic [7:0] r;
        r = v;
        if (tens)       r = (v >= 8'd50) ? v - 8'd50 : v + 8'd10;
        else if (units) r = (v == 8'd59) ? 8'd0 : v + 8'd1;
        return r;
    endfunction

    logic [7:0]                 hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [NUM_ALARMS-1:0][7:0] al_hour_q, al_hour_d, al_min_q, al_min_d, al_sec_q, al_sec_d;
    logic [7:0]                 tgt_hour_q, tgt_hour_d, tgt_min_q, tgt_min_d, tgt_sec_q, tgt_sec_d;
    logic [7:0]                 ring_cnt_q, ring_cnt_d;
    logic [AW-1:0]              ring_id_q, ring_id_d;
    state_e                     state_q, state_d;
    logic                       chk_q, chk_d;

    logic          mode_adj, mode_set, mode_run, sel_ok, match_ok, hit;
    logic [AW-1:0] hit_id;
    logic [7:0]    snz_min_sum;

    assign mode_adj = (mode == 2'b01);
    assign mode_set = (mode == 2'b10);
    assign mode_run = !mode_adj && !mode_set;
    assign sel_ok   = (32'(alarm_sel) < NUM_ALARMS);
    // chk_q marks the cycle right after a tick_sec update; matches are only taken then
    assign chk_d    = tick_sec && !mode_adj;
    assign match_ok = chk_q && mode_run;

    always_comb begin
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        al_sec_d  = al_sec_q;
        if (mode_adj) begin
            if (tick_adj) begin
                hour_d = edit_hour(hour_q, adjustline[5], adjustline[4]);
                min_d  = edit_ms(min_q, adjustline[3], adjustline[2]);
                sec_d  = edit_ms(sec_q, adjustline[1], adjustline[0]);
            end
        end else if (tick_sec) begin
            if (sec_q == 8'd59) begin
                sec_d = 8'd0;
                if (min_q == 8'd59) begin
                    min_d  = 8'd0;
                    hour_d = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
                end else begin
                    min_d = min_q + 8'd1;
                end
            end else begin
                sec_d = sec_q + 8'd1;
            end
        end
        if (mode_set && tick_adj && sel_ok) begin
            al_hour_d[alarm_sel] = edit_hour(al_hour_q[alarm_sel], adjustline[5], adjustline[4]);
            al_min_d[alarm_sel]  = edit_ms(al_min_q[alarm_sel], adjustline[3], adjustline[2]);
            al_sec_d[alarm_sel]  = edit_ms(al_sec_q[alarm_sel], adjustline[1], adjustline[0]);
        end
    end

    // Scan high to low so the lowest matching slot is the one left standing
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (alarm_en[k] && al_hour_q[k] == hour_q && al_min_q[k] == min_q &&
                al_sec_q[k] == sec_q) begin
                hit    = 1'b1;
                hit_id = AW'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ring_cnt_d  = ring_cnt_q;
        ring_id_d   = ring_id_q;
        tgt_hour_d  = tgt_hour_q;
        tgt_min_d   = tgt_min_q;
        tgt_sec_d   = tgt_sec_q;
        snz_min_sum = min_q + 8'(SNOOZE_MIN);
        if (mode_adj) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match_ok && hit) begin
                        state_d    = RING;
                        ring_id_d  = hit_id;
                        ring_cnt_d = 8'd0;
                    end
                end
                RING: begin
                    if (dismiss) begin
                        state_d = IDLE;
                    end else if (snooze) begin
                        state_d   = SNOOZE;
                        tgt_sec_d = sec_q;
                        if (snz_min_sum >= 8'd60) begin
                            tgt_min_d  = snz_min_sum - 8'd60;
                            tgt_hour_d = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
                        end else begin
                            tgt_min_d  = snz_min_sum;
                            tgt_hour_d = hour_q;
                        end
                    end else if (tick_sec) begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                        if (ring_cnt_q + 8'd1 == 8'(RING_SECS)) state_d = IDLE;
                    end
                end
                SNOOZE: begin
                    if (dismiss || !alarm_en[ring_id_q]) begin
                        state_d = IDLE;
                    end else if (match_ok && hour_q == tgt_hour_q && min_q == tgt_min_q &&
                                 sec_q == tgt_sec_q) begin
                        state_d    = RING;
                        ring_cnt_d = 8'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            al_hour_q  <= '0;
            al_min_q   <= '0;
            al_sec_q   <= '0;
            tgt_hour_q <= '0;
            tgt_min_q  <= '0;
            tgt_sec_q  <= '0;
            ring_cnt_q <= '0;
            ring_id_q  <= '0;
            state_q    <= IDLE;
            chk_q      <= 1'b0;
        end else begin
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            al_hour_q  <= al_hour_d;
            al_min_q   <= al_min_d;
            al_sec_q   <= al_sec_d;
            tgt_hour_q <= tgt_hour_d;
            tgt_min_q  <= tgt_min_d;
            tgt_sec_q  <= tgt_sec_d;
            ring_cnt_q <= ring_cnt_d;
            ring_id_q  <= ring_id_d;
            state_q    <= state_d;
            chk_q      <= chk_d;
        end
    end

    always_comb begin
        dis_hour = hour_q;
        dis_min  = min_q;
        dis_sec  = sec_q;
        if (mode_set) begin
            dis_hour = sel_ok ? al_hour_q[alarm_sel] : 8'd0;
            dis_min  = sel_ok ? al_min_q[alarm_sel]  : 8'd0;
            dis_sec  = sel_ok ? al_sec_q[alarm_sel]  : 8'd0;
        end
    end

    assign hour      = hour_q;
    assign minute    = min_q;
    assign second    = sec_q;
    assign ringing   = (state_q == RING);
    assign ring_id   = ring_id_q;
    assign adjusting = mode_adj;
    assign setting   = mode_set;
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi: vector table for edit/display behaviour,
// hand-written sequences for rollover, ring timing, priority, snooze and reset.
module tb_alarm_clock_multi;
    logic       clock, rst, tick_sec, tick_adj, snooze, dismiss;
    logic [1:0] mode, alarm_sel;
    logic [5:0] adjustline;
    logic [3:0] alarm_en;
    logic [7:0] hour, minute, second, dis_hour, dis_min, dis_sec;
    logic       ringing, adjusting, setting;
    logic [1:0] ring_id;

    int checks = 0;
    int errors = 0;

    alarm_clock_multi dut (
        .clock(clock), .rst(rst), .tick_sec(tick_sec), .tick_adj(tick_adj),
        .mode(mode), .alarm_sel(alarm_sel), .adjustline(adjustline),
        .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss),
        .hour(hour), .minute(minute), .second(second),
        .dis_hour(dis_hour), .dis_min(dis_min), .dis_sec(dis_sec),
        .ringing(ringing), .ring_id(ring_id), .adjusting(adjusting), .setting(setting)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst_n;
        logic [1:0] mode;
        logic       ts;
        logic       ta;
        logic [5:0] adj;
        logic [1:0] sel;
        int         h, m, s, dh, dm, ds;
    } vec_t;

    vec_t tbl[$];

    // mode 01 row: display follows time
    function automatic vec_t va(input logic ts, input logic ta, input logic [5:0] adj,
                                input int h, input int m, input int s);
        vec_t r;
        r.rst_n = 1'b1; r.mode = 2'b01; r.ts = ts; r.ta = ta; r.adj = adj; r.sel = 2'd0;
        r.h = h; r.m = m; r.s = s; r.dh = h; r.dm = m; r.ds = s;
        return r;
    endfunction

    // mode 10 row with time parked at 00:00:00: display shows alarm[sel]
    function automatic vec_t vs(input logic [1:0] sel, input logic ta, input int dh,
                                input int dm, input int ds);
        vec_t r;
        r.rst_n = 1'b1; r.mode = 2'b10; r.ts = 1'b0; r.ta = ta; r.adj = 6'b000001; r.sel = sel;
        r.h = 0; r.m = 0; r.s = 0; r.dh = dh; r.dm = dm; r.ds = ds;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        tick_sec = 1'b1;
        step();
        tick_sec = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic prog(input logic [1:0] sel, input int n);
        mode = 2'b10; alarm_sel = sel; adjustline = 6'b000001; tick_adj = 1'b1;
        repeat (n) step();
        tick_adj = 1'b0; adjustline = 6'b0; mode = 2'b00; alarm_sel = 2'd0;
    endtask

    initial begin
        logic rang;
        vec_t rr;
        rst = 1'b0; tick_sec = 1'b0; tick_adj = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        mode = 2'b00; alarm_sel = 2'd0; adjustline = 6'b0; alarm_en = 4'b0;

        tbl.push_back(va(1, 1, 6'b000001,  0,  0,  0));
        tbl.push_back(va(1, 0, 6'b111111,  0,  0,  0));
        tbl.push_back(va(1, 1, 6'b100101, 10,  1,  1));
        tbl.push_back(va(1, 1, 6'b101010, 20, 11, 11));
        tbl.push_back(va(1, 1, 6'b100000,  0, 11, 11));
        tbl.push_back(va(1, 1, 6'b111111, 10, 21, 21));
        tbl.push_back(va(1, 1, 6'b011010, 11, 31, 31));
        tbl.push_back(va(1, 1, 6'b011010, 12, 41, 41));
        tbl.push_back(va(1, 1, 6'b011010, 13, 51, 51));
        tbl.push_back(va(1, 1, 6'b101010, 23,  1,  1));
        tbl.push_back(va(1, 1, 6'b010101,  0,  2,  2));
        tbl.push_back(va(1, 1, 6'b100000, 10,  2,  2));
        tbl.push_back(va(1, 1, 6'b010000, 11,  2,  2));
        tbl.push_back(va(1, 1, 6'b010000, 12,  2,  2));
        tbl.push_back(va(1, 1, 6'b010000, 13,  2,  2));
        tbl.push_back(va(1, 1, 6'b010000, 14,  2,  2));
        tbl.push_back(va(1, 1, 6'b100000,  4,  2,  2));
        rr = va(0, 0, 6'b0, 0, 0, 0); rr.rst_n = 1'b0; rr.mode = 2'b00;
        tbl.push_back(rr);
        for (int k = 1; k <= 5; k++) tbl.push_back(vs(2'd2, 1, 0, 0, k));
        tbl.push_back(vs(2'd0, 0, 0, 0, 0));
        tbl.push_back(vs(2'd2, 0, 0, 0, 5));

        // Reset state
        step(); step();
        rst = 1'b1;
        check("rst_hour", hour, 0);
        check("rst_min", minute, 0);
        check("rst_sec", second, 0);
        check("rst_ringing", ringing, 0);
        check("rst_ring_id", ring_id, 0);
        check("rst_dis_sec", dis_sec, 0);
        check("rst_adjusting", adjusting, 0);
        check("rst_setting", setting, 0);

        // Full-day rollover
        rang = 1'b0;
        tick_sec = 1'b1;
        for (int i = 0; i < 86399; i++) begin
            step();
            if (ringing) rang = 1'b1;
        end
        check("roll_h23", hour, 23);
        check("roll_m59", minute, 59);
        check("roll_s59", second, 59);
        step();
        check("roll_h0", hour, 0);
        check("roll_m0", minute, 0);
        check("roll_s0", second, 0);
        check("roll_no_ring", rang, 0);
        repeat (59) step();
        tick_sec = 1'b0;
        check("pre_tbl_s59", second, 59);

        // Vector table: adjust edits, reset, alarm programming and display mux
        foreach (tbl[i]) begin
            rst = tbl[i].rst_n; mode = tbl[i].mode; tick_sec = tbl[i].ts;
            tick_adj = tbl[i].ta; adjustline = tbl[i].adj; alarm_sel = tbl[i].sel;
            step();
            check($sformatf("vec%0d_hour", i), hour, tbl[i].h);
            check($sformatf("vec%0d_min", i), minute, tbl[i].m);
            check($sformatf("vec%0d_sec", i), second, tbl[i].s);
            check($sformatf("vec%0d_dis_hour", i), dis_hour, tbl[i].dh);
            check($sformatf("vec%0d_dis_min", i), dis_min, tbl[i].dm);
            check($sformatf("vec%0d_dis_sec", i), dis_sec, tbl[i].ds);
            check($sformatf("vec%0d_adjusting", i), adjusting, tbl[i].mode == 2'b01);
            check($sformatf("vec%0d_setting", i), setting, tbl[i].mode == 2'b10);
        end
        rst = 1'b1; mode = 2'b00; tick_sec = 1'b0; tick_adj = 1'b0;
        adjustline = 6'b0; alarm_sel = 2'd0;

        // Alarm[2] at 00:00:05: ring latency and auto-stop
        alarm_en = 4'b0100;
        repeat (4) tick();
        check("a_sec4", second, 4);
        tick_sec = 1'b1; step(); tick_sec = 1'b0;
        check("a_sec5", second, 5);
        check("a_ring_1clk", ringing, 0);
        step();
        check("a_ring_2clk", ringing, 1);
        check("a_ring_id", ring_id, 2);
        repeat (9) tick();
        check("a_ring_after9", ringing, 1);
        tick();
        check("a_ring_after10", ringing, 0);
        check("a_sec15", second, 15);

        // Priority between slots 1 and 3, then snooze and dismiss+snooze
        do_reset();
        check("b_rst_sec", second, 0);
        prog(2'd1, 3);
        prog(2'd3, 3);
        alarm_en = 4'b1010; mode = 2'b11;
        repeat (2) tick();
        tick_sec = 1'b1; step(); tick_sec = 1'b0; step();
        check("b_ring", ringing, 1);
        check("b_ring_id", ring_id, 1);
        snooze = 1'b1; step(); snooze = 1'b0;
        check("b_snoozed", ringing, 0);
        repeat (299) tick();
        check("b_min5", minute, 5);
        check("b_sec2", second, 2);
        check("b_no_early_ring", ringing, 0);
        tick_sec = 1'b1; step(); tick_sec = 1'b0; step();
        check("b_reRing", ringing, 1);
        check("b_reRing_id", ring_id, 1);
        snooze = 1'b1; dismiss = 1'b1; step(); snooze = 1'b0; dismiss = 1'b0;
        check("b_dismissed", ringing, 0);
        repeat (300) tick();
        check("b_min10", minute, 10);
        check("b_dismiss_wins", ringing, 0);
        mode = 2'b00;

        // Reset mid-ring, mode 01 abort, dismiss
        do_reset();
        prog(2'd1, 1);
        alarm_en = 4'b0010;
        tick();
        check("c_ring", ringing, 1);
        check("c_ring_id", ring_id, 1);
        rst = 1'b0; step(); rst = 1'b1;
        check("c_rst_ringing", ringing, 0);
        check("c_rst_ring_id", ring_id, 0);
        check("c_rst_sec", second, 0);
        tick();
        check("c_alarm_cleared_sec", second, 1);
        check("c_alarm_cleared", ringing, 0);
        prog(2'd1, 2);
        tick();
        check("c_ring2", ringing, 1);
        mode = 2'b01; step();
        check("c_adj_abort", ringing, 0);
        mode = 2'b00; step();
        check("c_stay_idle", ringing, 0);
        prog(2'd1, 1);
        tick();
        check("c_ring3", ringing, 1);
        dismiss = 1'b1; step(); dismiss = 1'b0;
        check("c_dismiss", ringing, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
